p_pmem_arbiter: RTL and testbench
=================================

// Module: p_pmem_arbiter
// PURPOSE
//   Shares one physical-memory line port between the pipelined I-cache and the D-cache.
//   Sits between both caches' pmem_* ports and the cacheline adaptor.
//   Grants one whole line transaction at a time and latches its command for its full duration.
//   Routes the response only to the granted cache.
//   Round-robin by default; fixed D-cache priority is selectable.
// PARAMETERS
//   s_line     256  line width in bits (pmem data buses)
//   s_addr     32   address width
//   D_PRIORITY 0    0: round-robin on simultaneous requests; 1: D-cache always wins ties
// PORTS
//   clk            in   1       system clock
//   rst            in   1       asynchronous, active-high reset
//   i_pmem_read    in   1       I-cache line read request (held until i_pmem_resp)
//   i_pmem_address in   s_addr  I-cache line address
//   i_pmem_resp    out  1       I-cache transaction done
//   i_pmem_rdata   out  s_line  read line to I-cache
//   d_pmem_read    in   1       D-cache line read request
//   d_pmem_write   in   1       D-cache line write-back request
//   d_pmem_address in   s_addr  D-cache line address
//   d_pmem_wdata   in   s_line  D-cache write-back line
//   d_pmem_resp    out  1       D-cache transaction done
//   d_pmem_rdata   out  s_line  read line to D-cache
//   pmem_read      out  1       read command to adaptor
//   pmem_write     out  1       write command to adaptor
//   pmem_address   out  s_addr  latched address to adaptor
//   pmem_wdata     out  s_line  latched write data to adaptor
//   pmem_resp      in   1       adaptor done (single-cycle pulse)
//   pmem_rdata     in   s_line  adaptor read line, valid with pmem_resp
// BEHAVIOUR
//   FSM states: IDLE, I_BUSY, D_BUSY, DONE.
//   Reset:
//     - state=IDLE; last_grant=I, so D wins the first tie in round-robin mode.
//     - pmem_read, pmem_write, i_pmem_resp and d_pmem_resp are 0.
//     - pmem_address and pmem_wdata are 0.
//   IDLE:
//     - I request = i_pmem_read; D request = d_pmem_read | d_pmem_write.
//     - One requester active: grant it.
//     - Both active: round-robin grants the side not in last_grant; D_PRIORITY=1 grants D.
//     - At the grant edge: latch address; for D also latch wdata and op.
//     - Go to I_BUSY or D_BUSY and update last_grant.
//     - D with read and write both set: write wins (write-back precedes refill).
//   I_BUSY / D_BUSY:
//     - pmem_read/pmem_write are driven from the latched op, registered.
//     - First assertion is the cycle after the grant edge, so request-to-command latency is 1 cycle.
//     - The command is held until pmem_resp, even if the requester drops its request.
//     - Requester inputs are ignored while busy; the second requester waits.
//   On pmem_resp:
//     - Same cycle, combinational: resp goes to the granted side only.
//     - The other side's resp stays 0.
//     - Next edge: pmem_read/pmem_write=0 and go to DONE.
//   DONE:
//     - One idle bubble so the served cache can deassert.
//     - Its request is not re-sampled in this cycle; then go to IDLE.
//   rdata: pmem_rdata is broadcast combinationally to both i_pmem_rdata and d_pmem_rdata.
//     Consumers qualify it with their own resp.
//   Throughput: back-to-back transactions for alternating requesters cost 2 cycles of overhead (grant + DONE).
//   pmem_resp in IDLE or DONE is spurious: ignored, and no resp is forwarded.
//   Reset mid-transaction: return to IDLE and drop the command.
//     The adaptor must also be reset; no resp is forwarded afterwards.
// TESTING
//   1. Reset, I read 0x0000_1000 alone:
//      pmem_read=1 with addr 0x1000 one cycle later; resp after 4 cycles -> i_pmem_resp=1 for 1 cycle, d_pmem_resp=0.
//   2. I read and D read asserted in the same cycle, D_PRIORITY=0:
//      D served first, then I; a second simultaneous pair is served I first.
//   3. D read+write both set, addr 0x2000, wdata 0xA5..A5:
//      pmem_write=1, pmem_read=0, pmem_wdata=0xA5..A5.
//   4. I read granted, I drops i_pmem_read mid-transaction:
//      pmem_read stays 1 until pmem_resp; the queued D waits, then starts after DONE.
//   5. Spurious pmem_resp in IDLE:
//      no i_/d_pmem_resp, state stays IDLE.
//   6. rst asserted while D_BUSY:
//      all outputs 0 immediately (asynchronous); first post-reset tie goes to D.

Source files
------------

// File: rtl/p_pmem_arbiter.sv
// p_pmem_arbiter
//   Two-client arbiter in front of the cacheline adaptor. One whole line
//   transaction is granted at a time (I-cache or D-cache). The command
//   (op, address, write data) is latched at the grant edge and held until
//   the adaptor answers. The single-cycle response is steered to the granted
//   client only. A one-cycle DONE bubble follows each transaction so that
//   the served cache can drop its request before the next arbitration.
//   Ties are broken round-robin, or always in favour of the D-cache when
//   D_PRIORITY is set.

module p_pmem_arbiter #(
    parameter int s_line     = 256,
    parameter int s_addr     = 32,
    parameter bit D_PRIORITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_pmem_read,
    input  logic [s_addr-1:0] i_pmem_address,
    output logic              i_pmem_resp,
    output logic [s_line-1:0] i_pmem_rdata,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [s_addr-1:0] d_pmem_address,
    input  logic [s_line-1:0] d_pmem_wdata,
    output logic              d_pmem_resp,
    output logic [s_line-1:0] d_pmem_rdata,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [s_addr-1:0] pmem_address,
    output logic [s_line-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [s_line-1:0] pmem_rdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_I_BUSY = 2'd1;
    localparam logic [1:0] ST_D_BUSY = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    logic [1:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              pmem_read_q, pmem_read_d;
    logic              pmem_write_q, pmem_write_d;
    logic [s_addr-1:0] pmem_address_q, pmem_address_d;
    logic [s_line-1:0] pmem_wdata_q, pmem_wdata_d;

    logic              i_req_s;
    logic              d_req_s;
    logic              d_wins_s;

    // Arbitration, command latching and transaction sequencing.
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;

        i_req_s  = i_pmem_read;
        d_req_s  = d_pmem_read | d_pmem_write;
        // D takes a tie under fixed priority, or when I was served last.
        d_wins_s = d_req_s & (~i_req_s | D_PRIORITY | (last_grant_q == GNT_I));

        case (state_q)
            ST_IDLE: begin
                if (d_wins_s) begin
                    state_d        = ST_D_BUSY;
                    last_grant_d   = GNT_D;
                    pmem_address_d = d_pmem_address;
                    pmem_wdata_d   = d_pmem_wdata;
                    // A dirty-victim write-back must reach memory before the refill.
                    pmem_write_d   = d_pmem_write;
                    pmem_read_d    = d_pmem_read & ~d_pmem_write;
                end else if (i_req_s) begin
                    state_d        = ST_I_BUSY;
                    last_grant_d   = GNT_I;
                    pmem_address_d = i_pmem_address;
                    pmem_read_d    = 1'b1;
                    pmem_write_d   = 1'b0;
                end else begin
                    state_d        = ST_IDLE;
                end
            end
            ST_I_BUSY, ST_D_BUSY: begin
                if (pmem_resp) begin
                    state_d      = ST_DONE;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                end else begin
                    state_d      = state_q;
                end
            end
            ST_DONE: begin
                // Bubble: the just-served request is stale here, do not sample it.
                state_d = ST_IDLE;
            end
            default: begin
                state_d      = ST_IDLE;
                pmem_read_d  = 1'b0;
                pmem_write_d = 1'b0;
            end
        endcase
    end

    // State, round-robin pointer and latched command registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            last_grant_q   <= GNT_I;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
        end
    end

    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_address_q;
    assign pmem_wdata   = pmem_wdata_q;

    // The response is steered same-cycle; outside a busy state it is spurious.
    assign i_pmem_resp  = pmem_resp & (state_q == ST_I_BUSY);
    assign d_pmem_resp  = pmem_resp & (state_q == ST_D_BUSY);

    // Read data is shared; each cache qualifies it with its own resp.
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_p_pmem_arbiter.sv
// Directed bench for p_pmem_arbiter (round-robin configuration).
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns later.

module tb_p_pmem_arbiter;

    localparam int SL = 256;
    localparam int SA = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_pmem_read;
    logic [SA-1:0] i_pmem_address;
    logic          i_pmem_resp;
    logic [SL-1:0] i_pmem_rdata;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [SA-1:0] d_pmem_address;
    logic [SL-1:0] d_pmem_wdata;
    logic          d_pmem_resp;
    logic [SL-1:0] d_pmem_rdata;
    logic          pmem_read;
    logic          pmem_write;
    logic [SA-1:0] pmem_address;
    logic [SL-1:0] pmem_wdata;
    logic          pmem_resp;
    logic [SL-1:0] pmem_rdata;

    int checks = 0;
    int errors = 0;

    logic [SL-1:0] pat_a5;
    logic [SL-1:0] pat_3c;
    logic [SL-1:0] rd_1;
    logic [SL-1:0] rd_2;

    p_pmem_arbiter #(.s_line(SL), .s_addr(SA), .D_PRIORITY(1'b0)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_resp    (i_pmem_resp),
        .i_pmem_rdata   (i_pmem_rdata),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_resp    (d_pmem_resp),
        .d_pmem_rdata   (d_pmem_rdata),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_resp      (pmem_resp),
        .pmem_rdata     (pmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [SL-1:0] got, input logic [SL-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Command currently presented to the adaptor.
    task automatic chk_cmd(input string tag, input logic rd, input logic wr, input logic [SA-1:0] addr);
        #1;
        chk({tag, "_rd"}, SL'(pmem_read), SL'(rd));
        chk({tag, "_wr"}, SL'(pmem_write), SL'(wr));
        chk({tag, "_addr"}, SL'(pmem_address), SL'(addr));
    endtask

    // Pulse pmem_resp for one cycle; check routing of resp and rdata.
    task automatic resp_pulse(input string tag, input logic exp_i, input logic exp_d, input logic [SL-1:0] rd);
        pmem_resp  = 1'b1;
        pmem_rdata = rd;
        #1;
        chk({tag, "_iresp"}, SL'(i_pmem_resp), SL'(exp_i));
        chk({tag, "_dresp"}, SL'(d_pmem_resp), SL'(exp_d));
        if (exp_i) chk({tag, "_irdata"}, i_pmem_rdata, rd);
        else       chk({tag, "_drdata"}, d_pmem_rdata, rd);
        cyc();
        pmem_resp = 1'b0;
    endtask

    initial begin
        pat_a5 = {32{8'hA5}};
        pat_3c = {32{8'h3C}};
        rd_1   = {8{32'hDEAD_BEEF}};
        rd_2   = {8{32'h1234_5678}};

        rst            = 1'b1;
        i_pmem_read    = 1'b0;
        i_pmem_address = 32'h0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = 32'h0;
        d_pmem_wdata   = '0;
        pmem_resp      = 1'b0;
        pmem_rdata     = '0;
        cyc();
        cyc();
        chk_cmd("rst", 1'b0, 1'b0, 32'h0);
        chk("rst_wdata", pmem_wdata, '0);
        chk("rst_iresp", SL'(i_pmem_resp), SL'(1'b0));
        chk("rst_dresp", SL'(d_pmem_resp), SL'(1'b0));
        rst = 1'b0;
        cyc();

        // 1: lone I read, command one cycle after request, resp after 4 cycles.
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_1000;
        #1;
        chk("t1_pre_rd", SL'(pmem_read), SL'(1'b0));
        cyc();
        chk_cmd("t1_cmd", 1'b1, 1'b0, 32'h0000_1000);
        cyc();
        cyc();
        cyc();
        chk_cmd("t1_hold", 1'b1, 1'b0, 32'h0000_1000);
        resp_pulse("t1", 1'b1, 1'b0, rd_1);
        i_pmem_read = 1'b0;
        chk_cmd("t1_done", 1'b0, 1'b0, 32'h0000_1000);
        chk("t1_iresp_off", SL'(i_pmem_resp), SL'(1'b0));
        cyc();

        // 2: tie after I was served -> D first; D re-requests during DONE,
        //    second tie -> I first, then the new D request.
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_3000;
        d_pmem_read    = 1'b1;
        d_pmem_address = 32'h0000_4000;
        cyc();
        chk_cmd("t2_g1", 1'b1, 1'b0, 32'h0000_4000);
        cyc();
        resp_pulse("t2_r1", 1'b0, 1'b1, rd_2);
        d_pmem_address = 32'h0000_5000;
        chk_cmd("t2_done1", 1'b0, 1'b0, 32'h0000_4000);
        cyc();
        chk_cmd("t2_idle1", 1'b0, 1'b0, 32'h0000_4000);
        cyc();
        chk_cmd("t2_g2", 1'b1, 1'b0, 32'h0000_3000);
        resp_pulse("t2_r2", 1'b1, 1'b0, rd_1);
        i_pmem_read = 1'b0;
        cyc();
        cyc();
        chk_cmd("t2_g3", 1'b1, 1'b0, 32'h0000_5000);
        resp_pulse("t2_r3", 1'b0, 1'b1, rd_1);
        d_pmem_read = 1'b0;
        cyc();

        // 3: D read+write together -> write-back issued.
        d_pmem_read    = 1'b1;
        d_pmem_write   = 1'b1;
        d_pmem_address = 32'h0000_2000;
        d_pmem_wdata   = pat_a5;
        cyc();
        chk_cmd("t3_cmd", 1'b0, 1'b1, 32'h0000_2000);
        chk("t3_wdata", pmem_wdata, pat_a5);
        d_pmem_wdata = '0;
        cyc();
        chk("t3_wdata_hold", pmem_wdata, pat_a5);
        resp_pulse("t3", 1'b0, 1'b1, rd_2);
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
        chk_cmd("t3_done", 1'b0, 1'b0, 32'h0000_2000);
        cyc();

        // 4: I drops request mid-transaction; queued D waits for DONE.
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_6000;
        cyc();
        i_pmem_read    = 1'b0;
        d_pmem_read    = 1'b1;
        d_pmem_address = 32'h0000_7000;
        chk_cmd("t4_cmd", 1'b1, 1'b0, 32'h0000_6000);
        cyc();
        chk_cmd("t4_hold1", 1'b1, 1'b0, 32'h0000_6000);
        cyc();
        chk_cmd("t4_hold2", 1'b1, 1'b0, 32'h0000_6000);
        resp_pulse("t4_r1", 1'b1, 1'b0, rd_1);
        chk_cmd("t4_done", 1'b0, 1'b0, 32'h0000_6000);
        cyc();
        chk_cmd("t4_idle", 1'b0, 1'b0, 32'h0000_6000);
        cyc();
        chk_cmd("t4_dgrant", 1'b1, 1'b0, 32'h0000_7000);
        resp_pulse("t4_r2", 1'b0, 1'b1, rd_2);
        d_pmem_read = 1'b0;
        cyc();

        // 5: spurious resp in IDLE is not forwarded; arbiter stays idle.
        pmem_resp = 1'b1;
        #1;
        chk("t5_iresp", SL'(i_pmem_resp), SL'(1'b0));
        chk("t5_dresp", SL'(d_pmem_resp), SL'(1'b0));
        cyc();
        pmem_resp = 1'b0;
        chk_cmd("t5_idle", 1'b0, 1'b0, 32'h0000_7000);
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_8000;
        cyc();
        chk_cmd("t5_grant", 1'b1, 1'b0, 32'h0000_8000);
        resp_pulse("t5_r", 1'b1, 1'b0, rd_1);
        i_pmem_read = 1'b0;
        cyc();

        // 6: async reset while D_BUSY; first tie afterwards goes to D.
        d_pmem_write   = 1'b1;
        d_pmem_address = 32'h0000_9000;
        d_pmem_wdata   = pat_3c;
        cyc();
        chk_cmd("t6_busy", 1'b0, 1'b1, 32'h0000_9000);
        chk("t6_wdata", pmem_wdata, pat_3c);
        #2;
        rst       = 1'b1;
        pmem_resp = 1'b1;
        #1;
        chk("t6_rst_rd", SL'(pmem_read), SL'(1'b0));
        chk("t6_rst_wr", SL'(pmem_write), SL'(1'b0));
        chk("t6_rst_addr", SL'(pmem_address), SL'(32'h0));
        chk("t6_rst_wdata", pmem_wdata, '0);
        chk("t6_rst_dresp", SL'(d_pmem_resp), SL'(1'b0));
        chk("t6_rst_iresp", SL'(i_pmem_resp), SL'(1'b0));
        d_pmem_write = 1'b0;
        cyc();
        rst       = 1'b0;
        pmem_resp = 1'b0;
        cyc();
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_A000;
        d_pmem_read    = 1'b1;
        d_pmem_address = 32'h0000_B000;
        cyc();
        chk_cmd("t6_tie", 1'b1, 1'b0, 32'h0000_B000);
        resp_pulse("t6_r", 1'b0, 1'b1, rd_2);
        d_pmem_read = 1'b0;
        i_pmem_read = 1'b0;
        cyc();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
